// File: rtl/pc_unit.sv
// pc_unit: program-counter stage of the single-cycle CPU.
// Holds curPC (instruction memory address), selects the next PC
// (sequential / branch / jump / hold), stops fetch on the halt opcode
// and counts retired instructions with a saturating counter.
// Optional feature macro: PC_BOUND_CHECK_EN adds the pc_fault port and
// a FAULT state that blocks out-of-range or misaligned next-PC values.
module pc_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [5:0]  HALT_OP   = 6'b111111,
    parameter int unsigned MEM_BYTES = 68
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        PCWre,
    input  logic [1:0]  PCSrc,
    input  logic [5:0]  op,
    input  logic [15:0] immediate,
    input  logic [25:0] jaddr,
    output logic [31:0] curPC,
    output logic [31:0] pc4,
    output logic        halted,
    output logic [31:0] instr_count
`ifdef PC_BOUND_CHECK_EN
    ,
    output logic        pc_fault
`endif
);

`ifdef PC_BOUND_CHECK_EN
    typedef enum logic [1:0] {
        S_START = 2'd0,
        S_RUN   = 2'd1,
        S_HALT  = 2'd2,
        S_FAULT = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        S_START = 2'd0,
        S_RUN   = 2'd1,
        S_HALT  = 2'd2
    } state_t;
`endif

    localparam logic [1:0] SRC_SEQ    = 2'b00;
    localparam logic [1:0] SRC_BRANCH = 2'b01;
    localparam logic [1:0] SRC_JUMP   = 2'b10;

    state_t      state;
    logic [31:0] pc_reg;
    logic [31:0] count_reg;
    logic        halted_reg;
    logic [31:0] branch_off;
    logic [31:0] next_pc;
    logic [31:0] count_inc;
    logic        is_halt_op;

    assign curPC       = pc_reg;
    assign instr_count = count_reg;
    assign halted      = halted_reg;

    // Sequential address and next-PC selection, purely combinational from curPC.
    always_comb begin
        pc4        = pc_reg + 32'd4;
        branch_off = {{14{immediate[15]}}, immediate, 2'b00};
        next_pc    = pc_reg;
        unique case (PCSrc)
            SRC_SEQ:    next_pc = pc4;
            SRC_BRANCH: next_pc = pc4 + branch_off;
            SRC_JUMP:   next_pc = {pc4[31:28], jaddr, 2'b00};
            default:    next_pc = pc_reg;
        endcase
    end

    // Saturating retire counter increment and halt-opcode decode.
    always_comb begin
        count_inc  = (count_reg == '1) ? count_reg : count_reg + 32'd1;
        is_halt_op = (op == HALT_OP);
    end

`ifdef PC_BOUND_CHECK_EN
    localparam logic [31:0] PC_LIMIT = 32'(MEM_BYTES);

    logic fault_reg;
    logic next_bad;

    assign pc_fault = fault_reg;

    // A next PC is rejected when it falls outside instruction memory or is not word aligned.
    always_comb begin
        next_bad = (next_pc >= PC_LIMIT) || (next_pc[1:0] != 2'b00);
    end

    // Control FSM with registered curPC, counter, halted and pc_fault.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state      <= S_START;
            pc_reg     <= RESET_PC;
            count_reg  <= '0;
            halted_reg <= 1'b0;
            fault_reg  <= 1'b0;
        end else begin
            case (state)
                S_START: state <= S_RUN;
                S_RUN: begin
                    if (PCWre) begin
                        // Halt opcode outranks a bad next PC in the same cycle.
                        if (is_halt_op) begin
                            count_reg  <= count_inc;
                            halted_reg <= 1'b1;
                            state      <= S_HALT;
                        end else if (next_bad) begin
                            fault_reg  <= 1'b1;
                            halted_reg <= 1'b1;
                            state      <= S_FAULT;
                        end else begin
                            pc_reg    <= next_pc;
                            count_reg <= count_inc;
                        end
                    end
                end
                S_HALT:  state <= S_HALT;
                S_FAULT: state <= S_FAULT;
                default: state <= S_START;
            endcase
        end
    end
`else
    logic unused_limit;

    // MEM_BYTES only matters for the bound check; keep it referenced for a clean build.
    always_comb begin
        unused_limit = (MEM_BYTES == 0);
    end

    // Control FSM with registered curPC, counter and halted.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state      <= S_START;
            pc_reg     <= RESET_PC;
            count_reg  <= '0;
            halted_reg <= 1'b0;
        end else begin
            case (state)
                S_START: state <= S_RUN;
                S_RUN: begin
                    if (PCWre) begin
                        if (is_halt_op) begin
                            count_reg  <= count_inc;
                            halted_reg <= 1'b1;
                            state      <= S_HALT;
                        end else begin
                            pc_reg    <= next_pc;
                            count_reg <= count_inc;
                        end
                    end
                end
                S_HALT:  state <= S_HALT;
                default: state <= S_START;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_pc_unit.sv
// Directed self-checking bench for pc_unit (default build, and
// PC_BOUND_CHECK_EN build when the macro is defined).
module tb_pc_unit;

    logic        CLK;
    logic        Reset;
    logic        PCWre;
    logic [1:0]  PCSrc;
    logic [5:0]  op;
    logic [15:0] immediate;
    logic [25:0] jaddr;
    logic [31:0] curPC;
    logic [31:0] pc4;
    logic        halted;
    logic [31:0] instr_count;
`ifdef PC_BOUND_CHECK_EN
    logic        pc_fault;
`else
    logic [31:0] w_curPC;
    logic [31:0] w_pc4;
    logic        w_halted;
    logic [31:0] w_instr_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    pc_unit #(
        .RESET_PC (32'h0000_0000),
        .HALT_OP  (6'b111111),
        .MEM_BYTES(68)
    ) dut (
        .CLK        (CLK),
        .Reset      (Reset),
        .PCWre      (PCWre),
        .PCSrc      (PCSrc),
        .op         (op),
        .immediate  (immediate),
        .jaddr      (jaddr),
        .curPC      (curPC),
        .pc4        (pc4),
        .halted     (halted),
        .instr_count(instr_count)
`ifdef PC_BOUND_CHECK_EN
        ,
        .pc_fault   (pc_fault)
`endif
    );

`ifndef PC_BOUND_CHECK_EN
    // Second instance near the top of the address space to observe wrap-around.
    pc_unit #(
        .RESET_PC (32'hFFFF_FFF8),
        .HALT_OP  (6'b111111),
        .MEM_BYTES(68)
    ) dut_wrap (
        .CLK        (CLK),
        .Reset      (Reset),
        .PCWre      (PCWre),
        .PCSrc      (PCSrc),
        .op         (op),
        .immediate  (immediate),
        .jaddr      (jaddr),
        .curPC      (w_curPC),
        .pc4        (w_pc4),
        .halted     (w_halted),
        .instr_count(w_instr_count)
    );
`endif

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, expected end of test");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    // Drive one set of inputs, take one rising edge, sample 1 time unit later.
    task automatic step(input logic we, input logic [1:0] src, input logic [5:0] o,
                        input logic [15:0] imm, input logic [25:0] ja);
        PCWre     = we;
        PCSrc     = src;
        op        = o;
        immediate = imm;
        jaddr     = ja;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        Reset = 1'b0; PCWre = 1'b1; PCSrc = 2'b00; op = 6'd0;
        immediate = 16'd0; jaddr = 26'd0;

        // 1: reset state and START cycle
        @(posedge CLK); #1;
        check("rst_pc", curPC, 32'h0);
        check("rst_cnt", instr_count, 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_pc4", pc4, 32'h4);
        @(negedge CLK);
        Reset = 1'b1;
        step(1'b1, 2'b00, 6'd0, 16'd0, 26'd0);
        check("start_pc", curPC, 32'h0);
        check("start_cnt", instr_count, 32'd0);
`ifndef PC_BOUND_CHECK_EN
        check("wrap_start", w_curPC, 32'hFFFF_FFF8);
`endif

        // 2: sequential fetch
        step(1'b1, 2'b00, 6'd0, 16'd0, 26'd0);
        check("seq1", curPC, 32'h04);
`ifndef PC_BOUND_CHECK_EN
        check("wrap1", w_curPC, 32'hFFFF_FFFC);
`endif
        step(1'b1, 2'b00, 6'd0, 16'd0, 26'd0);
        check("seq2", curPC, 32'h08);
`ifndef PC_BOUND_CHECK_EN
        check("wrap2", w_curPC, 32'h0000_0000);
`endif
        step(1'b1, 2'b00, 6'd0, 16'd0, 26'd0);
        check("seq3", curPC, 32'h0C);
        check("seq_cnt", instr_count, 32'd3);
        check("seq_pc4", pc4, 32'h10);
        for (int i = 0; i < 4; i++) step(1'b1, 2'b00, 6'd0, 16'd0, 26'd0);
        check("to_1c", curPC, 32'h1C);
        check("to_1c_cnt", instr_count, 32'd7);

        // 3: branch, first with write disabled
        step(1'b0, 2'b01, 6'd0, 16'hFFFE, 26'd0);
        check("nowr_pc", curPC, 32'h1C);
        check("nowr_cnt", instr_count, 32'd7);
        step(1'b1, 2'b01, 6'd0, 16'hFFFE, 26'd0);
        check("branch_pc", curPC, 32'h18);
        check("branch_cnt", instr_count, 32'd8);
        step(1'b1, 2'b11, 6'd0, 16'd0, 26'd0);
        check("hold_pc", curPC, 32'h18);
        check("hold_cnt", instr_count, 32'd9);
        for (int i = 0; i < 8; i++) step(1'b1, 2'b00, 6'd0, 16'd0, 26'd0);
        check("to_38", curPC, 32'h38);

        // 4: jump then halt
        step(1'b1, 2'b10, 6'd0, 16'd0, 26'h0000010);
        check("jump_pc", curPC, 32'h40);
        check("jump_cnt", instr_count, 32'd18);
        step(1'b1, 2'b01, 6'h3F, 16'h0004, 26'd0);
        check("halt_pc", curPC, 32'h40);
        check("halt_cnt", instr_count, 32'd19);
        check("halt_flag", 32'(halted), 32'd1);
        step(1'b1, 2'b00, 6'd0, 16'd0, 26'd0);
        step(1'b1, 2'b10, 6'd0, 16'd0, 26'h0000001);
        check("halt_frozen_pc", curPC, 32'h40);
        check("halt_frozen_cnt", instr_count, 32'd19);
        check("halt_frozen_flag", 32'(halted), 32'd1);

        // 5: asynchronous reset mid-cycle while halted
        #2;
        Reset = 1'b0;
        #1;
        check("areset_pc", curPC, 32'h0);
        check("areset_halted", 32'(halted), 32'd0);
        check("areset_cnt", instr_count, 32'd0);
        #1;
        Reset = 1'b1;
        step(1'b1, 2'b00, 6'd0, 16'd0, 26'd0);
        check("restart_pc", curPC, 32'h0);
        step(1'b1, 2'b00, 6'd0, 16'd0, 26'd0);
        check("restart_seq", curPC, 32'h4);
        check("restart_cnt", instr_count, 32'd1);
        step(1'b1, 2'b10, 6'd0, 16'd0, 26'h0000010);
        check("jump2_pc", curPC, 32'h40);

`ifdef PC_BOUND_CHECK_EN
        // 6: out-of-range next PC faults
        step(1'b1, 2'b00, 6'd0, 16'd0, 26'd0);
        check("fault_pc", curPC, 32'h40);
        check("fault_flag", 32'(pc_fault), 32'd1);
        check("fault_halted", 32'(halted), 32'd1);
        check("fault_cnt", instr_count, 32'd2);
        step(1'b1, 2'b10, 6'd0, 16'd0, 26'h0000001);
        check("fault_frozen_pc", curPC, 32'h40);

        // halt opcode outranks a bad next PC
        @(negedge CLK);
        Reset = 1'b0;
        #1;
        check("fault_reset", 32'(pc_fault), 32'd0);
        Reset = 1'b1;
        step(1'b1, 2'b00, 6'd0, 16'd0, 26'd0);
        step(1'b1, 2'b10, 6'd0, 16'd0, 26'h0000010);
        step(1'b1, 2'b00, 6'h3F, 16'd0, 26'd0);
        check("prio_halted", 32'(halted), 32'd1);
        check("prio_fault", 32'(pc_fault), 32'd0);
        check("prio_cnt", instr_count, 32'd2);
`else
        // out-of-range PC is issued unchanged
        step(1'b1, 2'b00, 6'd0, 16'd0, 26'd0);
        check("oob_pc", curPC, 32'h44);
        check("oob_cnt", instr_count, 32'd3);
        check("oob_halted", 32'(halted), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
